aes_job_scheduler: RTL and testbench
====================================

AES_JOB_SCHEDULER -- requirements
Module: aes_job_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 5000, max WAIT-state cycles before a job is aborted (range 1..65535).
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  in  2  per-channel job request.
REQ-005 SHALL have port req_ready  out  2  per-channel job accept.
REQ-006 SHALL have port req_mode  in  2  per-channel op: 0 encrypt, 1 decrypt.
REQ-007 SHALL have port req_data  in  256  channel n block at [128n+127:128n].
REQ-008 SHALL have port rsp_valid  out  2  per-channel result valid.
REQ-009 SHALL have port rsp_ready  in  2  per-channel result accept.
REQ-010 SHALL have port rsp_data  out  128  result block, shared by both channels.
REQ-011 SHALL have port rsp_err  out  1  result is a timeout abort.
REQ-012 SHALL have port eng_start  out  1  one-cycle job start pulse to the shared AES engine.
REQ-013 SHALL have port eng_mode  out  1  engine op, 0 encrypt / 1 decrypt.
REQ-014 SHALL have port eng_data  out  128  engine input block.
REQ-015 SHALL have port eng_done  in  1  engine completion pulse.
REQ-016 SHALL have port eng_result  in  128  engine output, valid while eng_done is high.
REQ-017 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, with one job in flight at a time.
REQ-019 In IDLE with any req_valid set, SHALL set req_ready for exactly one granted channel: the only requester, or the channel other than last_grant when both request.
REQ-020 req_ready SHALL be zero outside IDLE; on req_valid&req_ready it SHALL latch data/mode, update last_grant and go to ISSUE.
REQ-021 ISSUE SHALL assert eng_start for exactly one cycle, then go to WAIT with the wait counter cleared.
REQ-022 eng_data/eng_mode SHALL hold the latched job, stable from ISSUE through WAIT.
REQ-023 In WAIT, eng_done SHALL capture eng_result into rsp_data with rsp_err=0 and move to RESP.
REQ-024 In WAIT, after TIMEOUT_CYC cycles without eng_done, SHALL load rsp_data=0 and rsp_err=1 and move to RESP.
REQ-025 eng_done in the same cycle as timeout SHALL win (rsp_err=0).
REQ-026 eng_done outside WAIT SHALL be ignored.
REQ-027 RESP SHALL assert rsp_valid only for the granted channel, with rsp_data/rsp_err held stable until rsp_ready for that channel, then return to IDLE.
REQ-028 Latency: request handshake at cycle N gives eng_start at N+1; eng_done at cycle M gives rsp_valid at M+1; the earliest next grant is the cycle after the response handshake.

Reset
REQ-029 On rst_n low, at any state including mid-WAIT: state=IDLE, last_grant=1 (channel 0 wins the first tie), counter=0.
REQ-030 Reset SHALL clear all outputs to 0, including latched data/mode; a pending engine result SHALL be dropped.

Configuration
REQ-031 With macro AES_SCHED_TIMEOUT_EN defined, SHALL include the wait counter and timeout abort (REQ-024/025).
REQ-032 Without AES_SCHED_TIMEOUT_EN, SHALL omit the counter, WAIT SHALL exit only on eng_done, and rsp_err SHALL be tied to 0.

Verification
REQ-033 Ch0 encrypt, data 00112233445566778899aabbccddeeff, engine done after 10 cycles with 69c4e0d86a7b0430d8cdb78070b4c55a -> one eng_start at N+1, eng_mode=0; rsp_valid=01 at done+1 with that data, rsp_err=0.
REQ-034 Both channels continuously valid after reset -> grant order ch0, ch1, ch0, ch1; eng_mode follows each channel's req_mode.
REQ-035 rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_data stable throughout, req_ready=00, eng_start never pulses.
REQ-036 TIMEOUT_CYC=16, macro defined, eng_done never -> RESP entered after 16 WAIT cycles with rsp_data=0, rsp_err=1; a later stray eng_done is ignored.
REQ-037 eng_done on the 16th WAIT cycle (TIMEOUT_CYC=16) -> rsp_err=0 with rsp_data=eng_result.
REQ-038 rst_n pulsed low mid-WAIT -> all outputs 0 and busy=0 immediately; an eng_done after release produces no rsp_valid.

Source files
------------

// File: rtl/aes_job_scheduler.sv
// ---------------------------------------------------------------------------
// aes_job_scheduler
//
// Arbitrates two request channels onto one shared AES engine, one job in
// flight at a time. A granted job is latched, started on the engine with a
// one-cycle eng_start pulse, and its result (or a timeout abort) is returned
// on the response port of the channel that issued it.
//
// Optional feature macro: AES_SCHED_TIMEOUT_EN
//   defined   -> a wait counter aborts a job after TIMEOUT_CYC WAIT cycles
//                (rsp_data=0, rsp_err=1); eng_done in the final cycle wins.
//   undefined -> no counter; WAIT exits only on eng_done; rsp_err is 0.
//
// Parameters
//   TIMEOUT_CYC  max WAIT cycles before abort, 1..65535 (timeout build only)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-channel job handshake (ready only in IDLE)
//   req_mode          per-channel op, 0 encrypt / 1 decrypt
//   req_data          channel n block at [128n+127:128n]
//   rsp_valid/ready   per-channel result handshake
//   rsp_data/rsp_err  result block / timeout-abort flag, shared by channels
//   eng_start         one-cycle job start pulse to the engine
//   eng_mode/eng_data latched job, stable from ISSUE through WAIT
//   eng_done/result   engine completion pulse and its output block
//   busy              high whenever the scheduler is not IDLE
// ---------------------------------------------------------------------------
module aes_job_scheduler #(
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [1:0]   req_mode,
    input  logic [255:0] req_data,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_err,
    output logic         eng_start,
    output logic         eng_mode,
    output logic [127:0] eng_data,
    input  logic         eng_done,
    input  logic [127:0] eng_result,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e       state_q, state_d;
    // Channel granted most recently; it is also the channel of the job in
    // flight, so the response is routed with it.
    logic         last_grant_q, last_grant_d;
    logic [127:0] data_q, data_d;
    logic         mode_q, mode_d;
    logic [127:0] rsp_data_q, rsp_data_d;
    logic         grant_sel;

`ifdef AES_SCHED_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0]  cnt_q, cnt_d;
    logic         rsp_err_q, rsp_err_d;
`endif

    // An out-of-range TIMEOUT_CYC leaves this named scope in the elaborated
    // hierarchy, which makes a bad override easy to spot.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_timeout_cyc_out_of_range
    end

    // Round-robin between two: a lone requester wins, a tie goes to the
    // channel that was not granted last.
    always_comb begin
        case (req_valid)
            2'b10:   grant_sel = 1'b1;
            2'b11:   grant_sel = ~last_grant_q;
            default: grant_sel = 1'b0;
        endcase
    end

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        mode_d       = mode_q;
        rsp_data_d   = rsp_data_q;
`ifdef AES_SCHED_TIMEOUT_EN
        cnt_d        = cnt_q;
        rsp_err_d    = rsp_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                // req_ready is raised for the selected requester, so any
                // valid request here is a completed handshake.
                if (|req_valid) begin
                    last_grant_d = grant_sel;
                    data_d       = grant_sel ? req_data[255:128] : req_data[127:0];
                    mode_d       = req_mode[grant_sel];
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef AES_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // eng_done is checked first so it beats a same-cycle timeout.
                if (eng_done) begin
                    rsp_data_d = eng_result;
`ifdef AES_SCHED_TIMEOUT_EN
                    rsp_err_d  = 1'b0;
`endif
                    state_d    = RESP;
                end
`ifdef AES_SCHED_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready[last_grant_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs. The job/result data
    // registers are reset too, because all outputs must read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            data_q       <= '0;
            mode_q       <= 1'b0;
            rsp_data_q   <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
            cnt_q        <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            mode_q       <= mode_d;
            rsp_data_q   <= rsp_data_d;
`ifdef AES_SCHED_TIMEOUT_EN
            cnt_q        <= cnt_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE && |req_valid) ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid = (state_q == RESP) ? (last_grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = rsp_data_q;
`ifdef AES_SCHED_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif
    assign eng_start = (state_q == ISSUE);
    assign eng_mode  = mode_q;
    assign eng_data  = data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_job_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for aes_job_scheduler. A transaction-level model
// predicts the granted channel, the engine job and the response (including
// timeout aborts when AES_SCHED_TIMEOUT_EN is defined); DUT pins are
// compared at each step 1 ns after the rising edge.
module tb_aes_job_scheduler;

    localparam int unsigned TMO = 16;
`ifdef AES_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req_mode;
    logic [255:0] req_data;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_err;
    logic         eng_start;
    logic         eng_mode;
    logic [127:0] eng_data;
    logic         eng_done;
    logic [127:0] eng_result;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;
    int model_last  = 1;   // channel granted last, as the rules define it

    aes_job_scheduler #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_mode(eng_mode), .eng_data(eng_data),
        .eng_done(eng_done), .eng_result(eng_result),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"},  rsp_data,  0);
        check({tag, "_rsp_err"},   rsp_err,   0);
        check({tag, "_eng_start"}, eng_start, 0);
        check({tag, "_eng_mode"},  eng_mode,  0);
        check({tag, "_eng_data"},  eng_data,  0);
        check({tag, "_busy"},      busy,      0);
    endtask

    // One complete job: request, engine run for done_at WAIT cycles (or a
    // timeout), response held for 'hold' cycles, then accepted.
    task automatic run_job(input logic [1:0] valid, input logic [1:0] modes,
                           input logic [127:0] d0, input logic [127:0] d1,
                           input int done_at, input logic [127:0] result,
                           input int hold, input bit keep_valid);
        int           ch;
        logic [127:0] exp_in;
        logic [127:0] exp_rsp;
        logic         exp_err;
        logic [1:0]   exp_onehot;
        bit           ended;

        ch         = (valid == 2'b11) ? 1 - model_last : (valid[1] ? 1 : 0);
        exp_in     = ch ? d1 : d0;
        exp_onehot = ch ? 2'b10 : 2'b01;
        exp_rsp    = '0;
        exp_err    = 1'b0;

        req_valid = valid;
        req_mode  = modes;
        req_data  = {d1, d0};
        #1;
        check("grant", req_ready, exp_onehot);
        tick;                               // handshake edge
        if (!keep_valid) req_valid = 2'b00;
        model_last = ch;

        check("issue_start", eng_start, 1);
        check("issue_mode",  eng_mode,  modes[ch]);
        check("issue_data",  eng_data,  exp_in);
        check("issue_ready", req_ready, 0);
        check("issue_busy",  busy,      1);
        tick;

        ended = 0;
        for (int k = 1; !ended && k <= 200; k++) begin
            check("wait_start", eng_start, 0);
            check("wait_rsp",   rsp_valid, 0);
            check("wait_data",  eng_data,  exp_in);
            check("wait_mode",  eng_mode,  modes[ch]);
            eng_done   = (k == done_at);
            eng_result = (k == done_at) ? result : rand128();
            if (k == done_at) begin
                exp_rsp = result;
                exp_err = 1'b0;
                ended   = 1;
            end else if (TMO_EN && k == TMO) begin
                exp_rsp = '0;
                exp_err = 1'b1;
                ended   = 1;
            end
            tick;
            eng_done = 1'b0;
        end
        if (!ended) check("wait_bound", ended, 1);

        for (int h = 0; h <= hold; h++) begin
            check("resp_valid", rsp_valid, exp_onehot);
            check("resp_data",  rsp_data,  exp_rsp);
            check("resp_err",   rsp_err,   exp_err);
            check("resp_ready", req_ready, 0);
            check("resp_start", eng_start, 0);
            if (h < hold) begin
                // Ready from the other channel and a stray engine pulse
                // must both be ignored.
                rsp_ready  = ~exp_onehot;
                eng_done   = 1'b1;
                eng_result = rand128();
                tick;
                rsp_ready  = 2'b00;
                eng_done   = 1'b0;
            end
        end
        rsp_ready = exp_onehot;
        tick;
        rsp_ready = 2'b00;
        check("done_rsp", rsp_valid, 0);
        if (!keep_valid) check("done_busy", busy, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        req_mode   = 2'b00;
        req_data   = '0;
        rsp_ready  = 2'b00;
        eng_done   = 1'b0;
        eng_result = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // Both channels continuously valid: ch0, ch1, ch0, ch1.
        run_job(2'b11, 2'b10, rand128(), rand128(), 3, rand128(), 0, 1);
        run_job(2'b11, 2'b10, rand128(), rand128(), 2, rand128(), 0, 1);
        run_job(2'b11, 2'b10, rand128(), rand128(), 4, rand128(), 1, 1);
        run_job(2'b11, 2'b10, rand128(), rand128(), 1, rand128(), 0, 0);

        // Known-answer style job on channel 0.
        run_job(2'b01, 2'b00, 128'h00112233445566778899aabbccddeeff, rand128(),
                10, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 0);

        // Response back-pressured for 5 cycles.
        run_job(2'b10, 2'b10, rand128(), rand128(), 3, rand128(), 5, 0);

        // Stray engine pulse while IDLE.
        eng_done = 1'b1;
        tick;
        eng_done = 1'b0;
        check("idle_stray_busy", busy, 0);
        check("idle_stray_rsp",  rsp_valid, 0);

        // Timeout boundaries (plain completions in the default build).
        run_job(2'b01, 2'b01, rand128(), rand128(), 40, rand128(), 2, 0);
        run_job(2'b01, 2'b00, rand128(), rand128(), TMO, rand128(), 0, 0);
        run_job(2'b10, 2'b11, rand128(), rand128(), TMO - 1, rand128(), 0, 0);
        run_job(2'b10, 2'b00, rand128(), rand128(), TMO + 1, rand128(), 1, 0);

        // Randomized jobs.
        for (int n = 0; n < 24; n++) begin
            run_job(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
                    rand128(), rand128(), int'($urandom_range(1, 20)),
                    rand128(), int'($urandom_range(0, 3)), 0);
        end

        // Reset asserted in the middle of WAIT.
        req_valid = 2'b01;
        req_mode  = 2'b01;
        req_data  = {rand128(), rand128()};
        tick;
        req_valid = 2'b00;
        tick;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        check_all_zero("midwait_reset");
        model_last = 1;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        eng_done   = 1'b1;
        eng_result = rand128();
        tick;
        eng_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("post_reset_rsp",  rsp_valid, 0);
            check("post_reset_busy", busy, 0);
            tick;
        end
        // First tie after reset must go to channel 0 again.
        run_job(2'b11, 2'b01, rand128(), rand128(), 5, rand128(), 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
